// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared CPU definitions used by the fetch stage and its instruction-memory
// interface: the fetch FSM state encoding, the 32-bit word type, the NOP
// encoding loaded into IF/ID on reset, the default reset PC and the "no
// instruction yet" marker driven on pc_out out of reset.
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    // BOOT is the single idle cycle after reset; WAIT keeps a request open
    // while memory is not ready; HOLD parks the stage while the hazard unit
    // stalls, and also provides the one idle bus cycle after an abandoned
    // request.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam word_t NOP_INSTR        = 32'h0000_0000;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    localparam word_t PC_INVALID       = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory read bus between the fetch stage (master) and the
// instruction memory (slave).
//   imem_req   : master -> slave, read request
//   imem_addr  : master -> slave, read address, stable while req && !ready
//   imem_ready : slave -> master, request accepted, data valid same cycle
//   imem_rdata : slave -> master, instruction word
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ready;
    word_t imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// ---------------------------------------------------------------------------
// fetch_stage_pc_next_sel
// Combinational next fetch-PC priority mux: redirect > hold > sequential.
//   i_redirect    : take i_redirect_pc
//   i_hold        : keep the current fetch PC (no instruction accepted)
//   i_redirect_pc : branch/jump target
//   i_fetch_pc    : current fetch PC
//   o_next_pc     : fetch PC for the next cycle
// ---------------------------------------------------------------------------
module fetch_stage_pc_next_sel
    import fetch_stage_pkg::*;
#(
    parameter int unsigned PC_STEP = 4
) (
    input  logic  i_redirect,
    input  logic  i_hold,
    input  word_t i_redirect_pc,
    input  word_t i_fetch_pc,
    output word_t o_next_pc
);

    // Sequential increment wraps naturally at 32 bits.
    always_comb begin
        o_next_pc = i_fetch_pc + 32'(PC_STEP);
        if (i_redirect) begin
            o_next_pc = i_redirect_pc;
        end else if (i_hold) begin
            o_next_pc = i_fetch_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: issues reads on the instruction-memory bus and
// presents the returned instruction and its address to the IF/ID register.
//   clk         : clock, all state on posedge
//   reset       : asynchronous, active-low reset
//   stall       : hazard-unit hold of the presented instruction
//   redirect    : taken branch/jump this cycle, target on redirect_pc
//   redirect_pc : redirect target address
//   imem        : instruction-memory bus (master side)
//   pc_out      : address of the instruction presented to IF/ID
//   instr_out   : instruction presented to IF/ID
//   kill1       : IF/ID must load a NOP instead of instr_out this cycle
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t       RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          redirect,
    input  word_t         redirect_pc,
    fetch_stage_if.master imem,
    output word_t         pc_out,
    output word_t         instr_out,
    output logic          kill1
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    word_t        r_fetch_pc;
    word_t        r_pc_out;
    word_t        r_instr_out;
    word_t        w_next_pc;
    logic         r_valid;
    logic         w_valid_next;
    logic         w_redirect;
    logic         w_hold;
    logic         w_req;
    logic         w_capture;
    logic         w_abandon;

    // r_valid: pc_out/instr_out carry an instruction IF/ID has not consumed.
    // While that instruction is stalled we must neither fetch nor overwrite it.
    assign w_redirect = redirect && (r_state != BOOT);
    assign w_hold     = stall && r_valid;
    assign w_capture  = w_req && imem.imem_ready && !w_redirect;
    // A redirect while a request is open but not accepted must leave the bus
    // idle for one cycle before a different address may be presented.
    assign w_abandon  = w_redirect && w_req && !imem.imem_ready;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fetch_pc;
    assign pc_out         = r_pc_out;
    assign instr_out      = r_instr_out;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, request and kill. An instruction is consumed by IF/ID in any
    // cycle stall is low, so without a new capture the presented one expires.
    always_comb begin
        w_state_next = r_state;
        w_req        = ((r_state == FETCH) || (r_state == WAIT)) && !w_hold;
        w_valid_next = stall ? r_valid : 1'b0;
        kill1        = !r_valid || w_redirect;

        case (r_state)
            FETCH, WAIT: begin
                if (w_capture) begin
                    w_state_next = FETCH;
                end else if (w_hold) begin
                    w_state_next = HOLD;
                end else begin
                    w_state_next = WAIT;
                end
            end
            HOLD: begin
                w_state_next = w_hold ? HOLD : FETCH;
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase

        if (w_capture) begin
            w_valid_next = 1'b1;
        end

        if (w_redirect) begin
            w_valid_next = 1'b0;
            w_state_next = w_abandon ? HOLD : FETCH;
        end
    end

    fetch_stage_pc_next_sel #(
        .PC_STEP(PC_STEP)
    ) u_pc_next_sel (
        .i_redirect   (w_redirect),
        .i_hold       (!w_capture),
        .i_redirect_pc(redirect_pc),
        .i_fetch_pc   (r_fetch_pc),
        .o_next_pc    (w_next_pc)
    );

    // Fetch PC and the IF/ID-facing registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc  <= RESET_PC;
            r_pc_out    <= PC_INVALID;
            r_instr_out <= NOP_INSTR;
            r_valid     <= 1'b0;
        end else begin
            r_fetch_pc <= (r_state == BOOT) ? RESET_PC : w_next_pc;
            r_valid    <= w_valid_next;
            if (w_capture) begin
                r_pc_out    <= r_fetch_pc;
                r_instr_out <= imem.imem_rdata;
            end
        end
    end

endmodule
